// File: rtl/mx_pkg.sv
// mx_pkg: shared MX format encodings, element format lookup and output field widths.
package mx_pkg;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int WORD_W = 1 + EXP_W + MANT_W;

    localparam logic [1:0] PREC_INT8 = 2'b00;
    localparam logic [1:0] PREC_FP   = 2'b01;

    typedef enum logic [1:0] {FP_E2M3, FP_E3M2, FP_E4M3, FP_E5M2} fp_mode_e;
    typedef enum logic {IDLE, STREAM} mx_state_e;

    typedef struct packed {
        logic [2:0] e_len;
        logic [1:0] m_len;
        logic [3:0] bias;
    } fmt_t;

    // prec_mode[1] set selects E2M1 regardless of FP_mode
    function automatic fmt_t fmt_lookup(input logic e2m1, input fp_mode_e fm);
        return e2m1           ? {3'd2, 2'd1, 4'd1}  :
               fm == FP_E5M2 ? {3'd5, 2'd2, 4'd15} :
               fm == FP_E4M3 ? {3'd4, 2'd3, 4'd7}  :
               fm == FP_E3M2 ? {3'd3, 2'd2, 4'd3}  : {3'd2, 2'd3, 4'd1};
    endfunction
endpackage

// File: rtl/mx_elem_decode.sv
// mx_elem_decode: combinational decode of one quantized byte into a {sign, exp, mant} word.
module mx_elem_decode
    import mx_pkg::*;
#(
    parameter int M_out_width = MANT_W
) (
    input  logic [7:0]                   q,
    input  logic [7:0]                   shared_exp,
    input  logic [1:0]                   prec_mode,
    input  logic [1:0]                   fp_mode,
    output logic [EXP_W+M_out_width:0]   word
);
    fmt_t              fmt;
    logic              is_int, sign, hidden;
    logic [6:0]        e_fld, m_body, m_fld, frac_sh;
    logic [7:0]        mag;
    logic [2:0]        lead;
    logic signed [9:0] offset, exp_s;

    // Everything is reduced to an integer magnitude times 2^offset, then normalized on its leading one.
    always_comb begin
        fmt     = fmt_lookup(prec_mode[1], fp_mode_e'(fp_mode));
        is_int  = prec_mode == PREC_INT8;
        sign    = q[7];
        e_fld   = q[6:0] >> (3'd7 - fmt.e_len);
        m_body  = q[6:0] << fmt.e_len;
        m_fld   = m_body >> (3'd7 - {1'b0, fmt.m_len});
        hidden  = |e_fld;
        mag     = is_int ? (q[7] ? 8'd0 - q : q) : ((8'(hidden) << fmt.m_len) | 8'(m_fld));
        offset  = is_int ? -10'sd6 : 10'(hidden ? e_fld : 7'd1) - 10'(fmt.bias) - 10'(fmt.m_len);
        lead    = 3'd0;
        for (int i = 0; i < 8; i++) if (mag[i]) lead = 3'(i);
        exp_s   = 10'(shared_exp) + 10'(lead) + offset;
        frac_sh = 7'(mag << (3'd7 - lead));
        word    = shared_exp == 8'hFF ? {sign, 8'hFF, M_out_width'(1) << (M_out_width - 1)} :
                  mag == 8'd0         ? {sign, (EXP_W + M_out_width)'(0)} :
                  exp_s <= 0          ? {sign, (EXP_W + M_out_width)'(0)} :
                  exp_s > 254         ? {sign, 8'hFE, {M_out_width{1'b1}}} :
                                        {sign, exp_s[7:0], M_out_width'(frac_sh) << (M_out_width - 7)};
    end
endmodule

// File: rtl/mx_dequant_unit.sv
// mx_dequant_unit: buffers one MX block and streams it out one decoded row per handshake.
module mx_dequant_unit
    import mx_pkg::*;
#(
    parameter int LEN_BLK     = 8,
    parameter int WD_BLK      = 8,
    parameter int M_out_width = 23
) (
    input  logic                                       clk_i,
    input  logic                                       rstn,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [LEN_BLK-1:0][WD_BLK-1:0][7:0]        q_block,
    input  logic [7:0]                                 shared_exp,
    input  logic [1:0]                                 prec_mode,
    input  logic [1:0]                                 FP_mode,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [WD_BLK-1:0][EXP_W+M_out_width:0]     out_row,
    output logic [$clog2(LEN_BLK)-1:0]                 out_row_idx,
    output logic                                       out_last
);
    localparam int IDX_W = $clog2(LEN_BLK);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(LEN_BLK - 1);

    mx_state_e                          state_q, state_n;
    logic [IDX_W-1:0]                   row_q;
    logic [LEN_BLK-1:0][WD_BLK-1:0][7:0] blk_q;
    logic [7:0]                         se_q;
    logic [1:0]                         prec_q, fpm_q;
    logic                               accept;

    always_comb begin
        out_valid = state_q == STREAM;
        out_last  = out_valid && row_q == LAST_ROW;
        in_ready  = !out_valid || (out_ready && out_last);
        accept    = in_valid && in_ready;
        state_n   = accept ? STREAM : (out_valid && out_ready && out_last) ? IDLE : state_q;
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            row_q   <= '0;
            blk_q   <= '0;
            se_q    <= '0;
            prec_q  <= '0;
            fpm_q   <= '0;
        end else begin
            state_q <= state_n;
            if (accept) begin
                blk_q  <= q_block;
                se_q   <= shared_exp;
                prec_q <= prec_mode;
                fpm_q  <= FP_mode;
                row_q  <= '0;
            end else if (out_valid && out_ready) begin
                row_q  <= out_last ? '0 : row_q + 1'b1;
            end
        end
    end

    assign out_row_idx = row_q;

    for (genvar c = 0; c < WD_BLK; c++) begin : g_dec
        mx_elem_decode #(.M_out_width(M_out_width)) u_dec (
            .q          (blk_q[row_q][c]),
            .shared_exp (se_q),
            .prec_mode  (prec_q),
            .fp_mode    (fpm_q),
            .word       (out_row[c])
        );
    end
endmodule

// File: tb/tb_mx_dequant_unit.sv
// tb_mx_dequant_unit: directed and random blocks checked against a real-valued reference decoder.
module tb_mx_dequant_unit;
    localparam int LEN = 8;
    localparam int WD  = 8;
    localparam int MW  = 23;

    logic clk_i = 1'b0, rstn = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_last;
    logic [LEN-1:0][WD-1:0][7:0] q_block = '0, cur_q = '0;
    logic [7:0] shared_exp = '0, cur_se = '0;
    logic [1:0] prec_mode = '0, FP_mode = '0, cur_p = '0, cur_f = '0;
    logic [WD-1:0][8+MW:0] out_row;
    logic [2:0] out_row_idx;
    int vecs = 0, errs = 0;

    always #5 clk_i = ~clk_i;

    mx_dequant_unit #(.LEN_BLK(LEN), .WD_BLK(WD), .M_out_width(MW)) dut (
        .clk_i       (clk_i),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .q_block     (q_block),
        .shared_exp  (shared_exp),
        .prec_mode   (prec_mode),
        .FP_mode     (FP_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last)
    );

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else repeat (-n) r = r / 2.0;
        return r;
    endfunction

    // Decode to a real value, then re-encode as a single-precision style word.
    function automatic logic [31:0] ref_dec(input logic [7:0] q, input logic [7:0] se,
                                            input logic [1:0] p, input logic [1:0] f);
        int el, ml, ef, mf, b, e, v;
        real mag, val;
        logic s;
        if (p == 2'b00) begin
            v = int'($signed(q));
            s = v < 0;
            mag = real'(v < 0 ? -v : v) / 64.0;
        end else begin
            el = p[1] ? 2 : (f == 2'd3 ? 5 : f == 2'd2 ? 4 : f == 2'd1 ? 3 : 2);
            ml = p[1] ? 1 : (f == 2'd3 ? 2 : f == 2'd2 ? 3 : f == 2'd1 ? 2 : 3);
            s  = q[7];
            ef = (int'(q) >> (7 - el)) & ((1 << el) - 1);
            mf = (int'(q) >> (7 - el - ml)) & ((1 << ml) - 1);
            b  = (1 << (el - 1)) - 1;
            mag = ef > 0 ? (1.0 + mf / pow2(ml)) * pow2(ef - b) : (mf / pow2(ml)) * pow2(1 - b);
        end
        if (se == 8'hFF) return {s, 8'hFF, 23'h400000};
        if (mag == 0.0) return {s, 31'h0};
        val = mag * pow2(int'(se) - 127);
        e = 0;
        while (val >= 2.0) begin val = val / 2.0; e++; end
        while (val < 1.0) begin val = val * 2.0; e--; end
        if (e + 127 <= 0) return {s, 31'h0};
        if (e + 127 > 254) return {s, 8'hFE, 23'h7FFFFF};
        return {s, 8'(e + 127), 23'($rtoi((val - 1.0) * 8388608.0))};
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_blk(input logic [1:0] p, input logic [1:0] f, input logic [7:0] se);
        for (int r = 0; r < LEN; r++)
            for (int c = 0; c < WD; c++) q_block[r][c] = 8'($urandom);
        prec_mode = p;
        FP_mode = f;
        shared_exp = se;
    endtask

    // Latch the model copy at the accept edge, then scramble inputs to prove they are ignored.
    task automatic take;
        cur_q = q_block;
        cur_se = shared_exp;
        cur_p = prec_mode;
        cur_f = FP_mode;
        in_valid = 1'b0;
        set_blk(2'($urandom), 2'($urandom), 8'($urandom));
    endtask

    task automatic accept;
        in_valid = 1'b1;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        tick;
        take;
    endtask

    task automatic check_row(input int r);
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("row_idx", 64'(out_row_idx), 64'(r));
        chk("out_last", 64'(out_last), 64'(r == LEN - 1));
        for (int c = 0; c < WD; c++)
            chk($sformatf("elem r%0d c%0d q=%h p=%0d f=%0d se=%0d", r, c, cur_q[r][c], cur_p, cur_f, cur_se),
                64'(out_row[c]), 64'(ref_dec(cur_q[r][c], cur_se, cur_p, cur_f)));
    endtask

    task automatic drain(input int nrows, input int stall_row, input int stall_n);
        for (int r = 0; r < nrows; r++) begin
            if (r == stall_row) begin
                out_ready = 1'b0;
                repeat (stall_n) begin
                    check_row(r);
                    tick;
                end
                out_ready = 1'b1;
            end
            check_row(r);
            tick;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_last"}, 64'(out_last), 64'd0);
    endtask

    initial begin
        repeat (2) tick;
        chk_idle("reset");
        chk("reset_idx", 64'(out_row_idx), 64'd0);
        chk("reset_row", 64'(out_row[0]), 64'd0);
        rstn = 1'b1;
        out_ready = 1'b1;

        set_blk(2'b01, 2'b10, 8'd127);
        q_block[0][0] = 8'h38;
        q_block[0][1] = 8'hB8;
        accept;
        chk("e4m3_0x38", 64'(out_row[0]), 64'h3F800000);
        chk("e4m3_0xB8", 64'(out_row[1]), 64'hBF800000);
        drain(LEN, 2, 3);
        chk_idle("blk_done");

        set_blk(2'b00, 2'b00, 8'd127);
        q_block[0][0] = 8'h40;
        q_block[0][1] = 8'hC0;
        q_block[0][2] = 8'h00;
        q_block[0][3] = 8'h80;
        accept;
        chk("int8_0x40", 64'(out_row[0]), 64'h3F800000);
        chk("int8_0xC0", 64'(out_row[1]), 64'hBF800000);
        chk("int8_0x00", 64'(out_row[2]), 64'h00000000);
        chk("int8_0x80", 64'(out_row[3]), 64'hC0000000);
        drain(LEN, -1, 0);

        for (int k = 2; k < 4; k++) begin
            set_blk(2'(k), 2'($urandom), 8'd127);
            q_block[0][0] = 8'h10;
            accept;
            chk("e2m1_0x10", 64'(out_row[0]), 64'h3F000000);
            drain(LEN, -1, 0);
        end

        set_blk(2'b01, 2'b10, 8'd2);
        q_block[0][0] = 8'h08;
        accept;
        chk("e4m3_flush", 64'(out_row[0]), 64'h00000000);
        drain(LEN, -1, 0);

        set_blk(2'b01, 2'b11, 8'd254);
        q_block[0][0] = 8'h7B;
        accept;
        chk("e5m2_sat", 64'(out_row[0]), 64'h7F7FFFFF);
        drain(LEN, -1, 0);

        set_blk(2'b01, 2'b10, 8'hFF);
        q_block[0][0] = 8'h38;
        accept;
        chk("se_ff", 64'(out_row[0]), 64'h7FC00000);
        drain(LEN, -1, 0);

        for (int i = 0; i < 16; i++) begin
            set_blk(2'($urandom), 2'($urandom), (i % 4 == 0) ? 8'($urandom_range(0, 8)) :
                    (i % 4 == 1) ? 8'($urandom_range(245, 254)) : 8'($urandom));
            accept;
            drain(LEN, int'($urandom_range(0, LEN - 1)), int'($urandom_range(0, 2)));
            chk_idle("rand_done");
        end

        set_blk(2'b01, 2'b01, 8'd100);
        accept;
        drain(LEN - 1, -1, 0);
        check_row(LEN - 1);
        set_blk(2'b00, 2'b00, 8'd130);
        in_valid = 1'b1;
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        tick;
        take;
        drain(LEN, -1, 0);
        chk_idle("b2b_done");

        set_blk(2'b01, 2'b11, 8'd120);
        accept;
        drain(4, -1, 0);
        chk("pre_rst_idx", 64'(out_row_idx), 64'd4);
        rstn = 1'b0;
        #1;
        chk_idle("mid_rst");
        chk("mid_rst_idx", 64'(out_row_idx), 64'd0);
        tick;
        rstn = 1'b1;
        repeat (3) begin
            tick;
            chk("post_rst_valid", 64'(out_valid), 64'd0);
        end
        set_blk(2'b00, 2'b00, 8'd127);
        accept;
        drain(LEN, -1, 0);
        chk_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
